// File: rtl/stopwatch_pkg.sv
// Shared types for the centisecond stopwatch: FSM state encoding and BCD digit type.
package stopwatch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} sw_state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit with synchronous clear/increment, configurable top value and
// combinational carry-out (asserted when incremented while at MAX).
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter bcd_t MAX = BCD_MAX
) (
  input  logic clk_in,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output bcd_t value,
  output logic carry
);

  bcd_t value_q, value_d;

  assign carry = inc && (value_q == MAX);
  assign value = value_q;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc) begin
      value_d = carry ? '0 : value_q + 4'd1;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) value_q <= '0;
    else       value_q <= value_d;
  end

endmodule

// File: rtl/stopwatch_bcd.sv
// SS.cc BCD stopwatch fed by a synchronised 10 kHz tick; run/pause/clear FSM.
// Optional lap hold (snapshot display) enabled by defining STOPWATCH_LAP_HOLD_EN.
//
// state | meaning
// IDLE  | zeroed, waiting for start_stop
// RUN   | prescaler counts tick edges, digits advance
// PAUSE | digits and partial prescale frozen, tick edges ignored
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_CS = 100,
  parameter int SEC_MAX      = 59,
  parameter int SYNC_STAGES  = 2
) (
  input  logic clk_in,
  input  logic reset,
  input  logic tick_in,
  input  logic start_stop,
  input  logic clear,
`ifdef STOPWATCH_LAP_HOLD_EN
  input  logic lap,
`endif
  output bcd_t sec_tens,
  output bcd_t sec_ones,
  output bcd_t cs_tens,
  output bcd_t cs_ones,
  output logic running,
  output logic wrap
);

  localparam int PW = (TICKS_PER_CS > 1) ? $clog2(TICKS_PER_CS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_CS - 1);
  localparam bcd_t SEC_T_MAX = bcd_t'(SEC_MAX / 10);
  localparam bcd_t SEC_O_MAX = bcd_t'(SEC_MAX % 10);
  localparam bit   ONES_FULL = ((SEC_MAX % 10) == 9);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   tick_q, tick_d;
  sw_state_t              state_q, state_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic                   wrap_q, wrap_d;

  logic cs_inc, roll, dig_clr;
  logic co_c, ct_c, so_c, st_c;
  bcd_t cs_ones_live, cs_tens_live, sec_ones_live, sec_tens_live;
  logic [15:0] live, disp;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], tick_in};
    prev_d = sync_q[SYNC_STAGES-1];
    tick_d = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (start_stop) begin
      unique case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  assign running = (state_q == RUN);
  assign cs_inc  = running && tick_q && (presc_q == PRESC_LAST) && !clear;

  always_comb begin
    presc_d = presc_q;
    if (clear) begin
      presc_d = '0;
    end else if (running && tick_q) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
    end
  end

  // When SEC_MAX ends in 9 the natural carry out of sec_tens marks the rollover;
  // otherwise the limit has to be decoded explicitly.
  assign roll = ONES_FULL ? st_c
              : (cs_inc && (cs_tens_live == BCD_MAX) && (cs_ones_live == BCD_MAX)
                 && (sec_ones_live == SEC_O_MAX) && (sec_tens_live == SEC_T_MAX));
  assign dig_clr = clear || roll;
  assign wrap_d  = roll;

  bcd_digit #(.MAX(BCD_MAX)) u_cs_ones (
    .clk_in(clk_in), .reset(reset), .clr(dig_clr), .inc(cs_inc),
    .value(cs_ones_live), .carry(co_c)
  );
  bcd_digit #(.MAX(BCD_MAX)) u_cs_tens (
    .clk_in(clk_in), .reset(reset), .clr(dig_clr), .inc(co_c),
    .value(cs_tens_live), .carry(ct_c)
  );
  bcd_digit #(.MAX(BCD_MAX)) u_sec_ones (
    .clk_in(clk_in), .reset(reset), .clr(dig_clr), .inc(ct_c),
    .value(sec_ones_live), .carry(so_c)
  );
  bcd_digit #(.MAX(SEC_T_MAX)) u_sec_tens (
    .clk_in(clk_in), .reset(reset), .clr(dig_clr), .inc(so_c),
    .value(sec_tens_live), .carry(st_c)
  );

  assign live = {sec_tens_live, sec_ones_live, cs_tens_live, cs_ones_live};

`ifdef STOPWATCH_LAP_HOLD_EN
  logic        hold_q, hold_d;
  logic [15:0] snap_q, snap_d;

  always_comb begin
    hold_d = hold_q;
    snap_d = snap_q;
    if (clear) begin
      hold_d = 1'b0;
    end else if (lap && (state_q != IDLE)) begin
      hold_d = ~hold_q;
      if (!hold_q) snap_d = live;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      hold_q <= 1'b0;
      snap_q <= '0;
    end else begin
      hold_q <= hold_d;
      snap_q <= snap_d;
    end
  end

  assign disp = hold_q ? snap_q : live;
`else
  assign disp = live;
`endif

  assign {sec_tens, sec_ones, cs_tens, cs_ones} = disp;
  assign wrap = wrap_q;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      tick_q  <= 1'b0;
      state_q <= IDLE;
      presc_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      tick_q  <= tick_d;
      state_q <= state_d;
      presc_q <= presc_d;
      wrap_q  <= wrap_d;
    end
  end

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Randomised-timing bench for stopwatch_bcd against a centisecond-count reference model.
module tb_stopwatch_bcd;

  localparam int TICKS  = 2;
  localparam int SECMAX = 59;
  localparam int CS_MOD = (SECMAX + 1) * 100;

  logic clk_in = 1'b0;
  logic reset = 1'b1;
  logic tick_in = 1'b0;
  logic start_stop = 1'b0;
  logic clear = 1'b0;
`ifdef STOPWATCH_LAP_HOLD_EN
  logic lap = 1'b0;
`endif
  logic [3:0] sec_tens, sec_ones, cs_tens, cs_ones;
  logic running, wrap;
  logic [15:0] disp;

  int checks = 0;
  int failures = 0;
  int wrap_cycles = 0;

  // reference model: whole centiseconds, tick phase, mode 0=idle 1=run 2=pause
  int m_mode = 0;
  int m_ticks = 0;
  int m_cs = 0;
  int m_wraps = 0;
  bit m_hold = 1'b0;
  int m_snap = 0;

  always #10 clk_in = ~clk_in;

  assign disp = {sec_tens, sec_ones, cs_tens, cs_ones};

  stopwatch_bcd #(.TICKS_PER_CS(TICKS), .SEC_MAX(SECMAX), .SYNC_STAGES(2)) dut (
    .clk_in(clk_in),
    .reset(reset),
    .tick_in(tick_in),
    .start_stop(start_stop),
    .clear(clear),
`ifdef STOPWATCH_LAP_HOLD_EN
    .lap(lap),
`endif
    .sec_tens(sec_tens),
    .sec_ones(sec_ones),
    .cs_tens(cs_tens),
    .cs_ones(cs_ones),
    .running(running),
    .wrap(wrap)
  );

  always @(negedge clk_in) if (wrap === 1'b1) wrap_cycles++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int cs);
    return {4'(cs / 1000), 4'((cs / 100) % 10), 4'((cs / 10) % 10), 4'(cs % 10)};
  endfunction

  task automatic check_model(input string tag);
    check_eq({tag, "_digits"}, {16'h0, disp}, {16'h0, to_bcd(m_hold ? m_snap : m_cs)});
    check_eq({tag, "_running"}, {31'h0, running}, {31'h0, m_mode == 1});
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic model_tick();
    if (m_mode == 1) begin
      m_ticks++;
      if (m_ticks == TICKS) begin
        m_ticks = 0;
        m_cs++;
        if (m_cs == CS_MOD) begin
          m_cs = 0;
          m_wraps++;
        end
      end
    end
  endtask

  task automatic send_edges(input int n, input bit fast);
    for (int i = 0; i < n; i++) begin
      tick_in = 1'b1;
      repeat (fast ? 1 : $urandom_range(1, 3)) @(negedge clk_in);
      tick_in = 1'b0;
      repeat (fast ? 1 : $urandom_range(1, 3)) @(negedge clk_in);
      model_tick();
    end
    settle(5);
  endtask

  task automatic pulse(input bit ss, input bit clr);
    @(negedge clk_in);
    start_stop = ss;
    clear = clr;
    @(negedge clk_in);
    start_stop = 1'b0;
    clear = 1'b0;
    if (clr) begin
      m_mode = 0; m_cs = 0; m_ticks = 0; m_hold = 1'b0;
    end else if (ss) begin
      m_mode = (m_mode == 1) ? 2 : 1;
    end
  endtask

`ifdef STOPWATCH_LAP_HOLD_EN
  task automatic pulse_lap();
    @(negedge clk_in);
    lap = 1'b1;
    @(negedge clk_in);
    lap = 1'b0;
    if (m_mode != 0) begin
      if (!m_hold) m_snap = m_cs;
      m_hold = ~m_hold;
    end
  endtask
`endif

  initial begin
    settle(2);
    check_eq("rst_digits", {16'h0, disp}, 32'h0);
    check_eq("rst_running", {31'h0, running}, 32'h0);
    check_eq("rst_wrap", {31'h0, wrap}, 32'h0);
    reset = 1'b0;
    settle(2);

    // idle ignores ticks
    send_edges(3 * TICKS, 1'b0);
    check_eq("idle_no_count", {16'h0, disp}, 32'h0);

    // 1: first centisecond, then ten
    pulse(1'b1, 1'b0);
    send_edges(TICKS, 1'b0);
    check_eq("t1_one_cs", {16'h0, disp}, 32'h0001);
    send_edges(9 * TICKS, 1'b0);
    check_eq("t1_ten_cs", {16'h0, disp}, 32'h0010);
    check_eq("t1_running", {31'h0, running}, 32'h1);

    // 2: full range and rollover
    send_edges((5999 - 10) * TICKS, 1'b1);
    check_eq("t2_max", {16'h0, disp}, 32'h5999);
    check_eq("t2_no_wrap_yet", wrap_cycles, 32'h0);
    send_edges(TICKS, 1'b0);
    check_eq("t2_rolled", {16'h0, disp}, 32'h0000);
    check_eq("t2_wrap_one_cycle", wrap_cycles, m_wraps);
    check_eq("t2_running", {31'h0, running}, 32'h1);

    // 3: pause holds digits and partial prescale
    send_edges(327 * TICKS, 1'b1);
    check_eq("t3_at_0327", {16'h0, disp}, 32'h0327);
    pulse(1'b1, 1'b0);
    send_edges(500, 1'b0);
    check_eq("t3_paused", {16'h0, disp}, 32'h0327);
    check_eq("t3_paused_run", {31'h0, running}, 32'h0);
    pulse(1'b1, 1'b0);
    send_edges(TICKS, 1'b0);
    check_eq("t3_resumed", {16'h0, disp}, 32'h0328);

    // 4: clear beats start_stop
    send_edges((1050 - 328) * TICKS, 1'b1);
    check_eq("t4_at_1050", {16'h0, disp}, 32'h1050);
    pulse(1'b1, 1'b1);
    check_eq("t4_cleared", {16'h0, disp}, 32'h0000);
    check_eq("t4_running", {31'h0, running}, 32'h0);
    send_edges(3 * TICKS, 1'b0);
    check_eq("t4_idle_hold", {16'h0, disp}, 32'h0000);

    // 5: asynchronous reset between edges
    pulse(1'b1, 1'b0);
    send_edges(707 * TICKS, 1'b1);
    check_eq("t5_at_0707", {16'h0, disp}, 32'h0707);
    @(posedge clk_in);
    #5 reset = 1'b1;
    #2;
    check_eq("t5_async_digits", {16'h0, disp}, 32'h0);
    check_eq("t5_async_running", {31'h0, running}, 32'h0);
    @(negedge clk_in);
    reset = 1'b0;
    m_mode = 0; m_cs = 0; m_ticks = 0; m_hold = 1'b0;
    send_edges(4 * TICKS, 1'b0);
    check_eq("t5_idle_after_rst", {16'h0, disp}, 32'h0);
    pulse(1'b1, 1'b0);
    send_edges(TICKS, 1'b0);
    check_eq("t5_counts_again", {16'h0, disp}, 32'h0001);

`ifdef STOPWATCH_LAP_HOLD_EN
    // 6: lap snapshot and release
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    send_edges(1234 * TICKS, 1'b1);
    pulse_lap();
    check_eq("t6_lap_snap", {16'h0, disp}, 32'h1234);
    send_edges(2 * TICKS, 1'b0);
    check_eq("t6_lap_held", {16'h0, disp}, 32'h1234);
    pulse_lap();
    check_eq("t6_lap_release", {16'h0, disp}, 32'h1236);
    pulse_lap();
    pulse(1'b0, 1'b1);
    check_eq("t6_clear_drops_hold", {16'h0, disp}, 32'h0);
`endif

    // random mix of tick bursts, start_stop and clear
    for (int it = 0; it < 40; it++) begin
      int op;
      op = int'($urandom_range(0, 9));
      case (op)
        0:       pulse(1'b0, 1'b1);
        1, 2:    pulse(1'b1, 1'b0);
        3:       pulse(1'b1, 1'b1);
        default: send_edges(int'($urandom_range(1, 40)), 1'b0);
      endcase
      check_model("rand");
    end
    check_eq("wrap_total", wrap_cycles, m_wraps);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
